// File: rtl/uart_pkg.sv
// Shared states and constants for the oversampling UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   // Oversample indices: middle of the start bit, then one full bit period later
   localparam logic [3:0] UART_MID_START = 4'd7;
   localparam logic [3:0] UART_MID_BIT   = 4'd15;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY  = 3'd3,
`endif
      STOP    = 3'd4,
      RECOVER = 3'd5
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running system-clock divider producing a one-cycle oversample tick
// every CLK_DIV clocks.
module uart_rx_tick #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling 8N1 UART receiver with valid/ready output, framing and overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_rx_os #(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   import uart_pkg::*;

   localparam int OS_W = $clog2(UART_OVERSAMPLE);
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic tick;
   logic sync_q;
   logic s_in;

   uart_rx_state_t state, state_next;
   logic [OS_W-1:0]           os_cnt, os_next;
   logic [2:0]                bit_cnt, bit_next;
   logic [UART_DATA_BITS-1:0] shift, shift_next;
   logic                      deliver;
   logic                      frame_bad;

   uart_rx_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_bad_next;
   logic par_report;
`endif

   always_comb begin
      state_next = state;
      os_next    = os_cnt;
      bit_next   = bit_cnt;
      shift_next = shift;
      deliver    = 1'b0;
      frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_next = par_bad;
      par_report   = 1'b0;
`endif
      if (tick) begin
         case (state)
            IDLE: begin
               if (!s_in) begin
                  state_next = START;
                  os_next    = '0;
               end
            end
            START: begin
               os_next = os_cnt + OS_W'(1);
               if (os_cnt == UART_MID_START) begin
                  if (!s_in) begin
                     state_next = DATA;
                     os_next    = '0;
                     bit_next   = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
            DATA: begin
               os_next = os_cnt + OS_W'(1);
               if (os_cnt == UART_MID_BIT) begin
                  shift_next = {s_in, shift[UART_DATA_BITS-1:1]};
                  bit_next   = bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               os_next = os_cnt + OS_W'(1);
               if (os_cnt == UART_MID_BIT) begin
                  par_bad_next = (^shift) ^ s_in;
                  state_next   = STOP;
               end
            end
`endif
            STOP: begin
               os_next = os_cnt + OS_W'(1);
               if (os_cnt == UART_MID_BIT) begin
`ifdef UART_RX_PARITY_EN
                  par_report = par_bad;
`endif
                  if (s_in) begin
                     deliver    = 1'b1;
                     state_next = IDLE;
                  end else begin
                     frame_bad  = 1'b1;
                     state_next = RECOVER;
                  end
               end
            end
            // Holding here while the line is low keeps a break from looking like a start bit
            RECOVER: begin
               if (s_in) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= 1'b1;
         s_in    <= 1'b1;
         state   <= IDLE;
         os_cnt  <= '0;
         bit_cnt <= '0;
         shift   <= '0;
      end else begin
         sync_q  <= in;
         s_in    <= sync_q;
         state   <= state_next;
         os_cnt  <= os_next;
         bit_cnt <= bit_next;
         shift   <= shift_next;
      end
   end

   // A byte arriving while the previous one is still unclaimed is dropped
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frame_bad;
         overrun   <= deliver && valid && !ready;
         if (deliver && (!valid || ready)) begin
            data  <= shift;
            valid <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad    <= par_bad_next;
         parity_err <= par_report;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed testbench for uart_rx_os at CLK_DIV=2 (32 clocks per bit).
// Build with UART_RX_PARITY_EN defined to also exercise the parity bit.
module tb_uart_rx_os;

   localparam int CLK_DIV  = 2;
   localparam int BIT_CLKS = CLK_DIV * 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       in    = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int errors = 0;
   int checks = 0;

   int         valid_seen = 0;
   int         fe_seen    = 0;
   int         ov_seen    = 0;
   int         pe_seen    = 0;
   logic [7:0] last_data  = 8'h00;
   int v0, f0, o0, p0;

`ifdef UART_RX_PARITY_EN
   logic bad_parity = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_rx_os #(.CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   // Counts output pulses and records the byte seen whenever valid is high
   always @(negedge clk) begin
      if (valid) begin
         valid_seen <= valid_seen + 1;
         last_data  <= data;
      end
      if (frame_err)  fe_seen <= fe_seen + 1;
      if (overrun)    ov_seen <= ov_seen + 1;
      if (parity_err) pe_seen <= pe_seen + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      in = 1'b0;
      waitClocks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         in = b[i];
         waitClocks(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      in = (^b) ^ bad_parity;
      waitClocks(BIT_CLKS);
`endif
      in = stop_bit;
      waitClocks(BIT_CLKS);
      in = 1'b1;
   endtask

   task automatic snapCounts();
      v0 = valid_seen;
      f0 = fe_seen;
      o0 = ov_seen;
      p0 = pe_seen;
   endtask

   initial begin
      $display("[TB] uart_rx_os directed test, CLK_DIV=%0d", CLK_DIV);

      // Reset state
      rst_n = 1'b0;
      waitClocks(4);
      checkOutput("reset_data", 32'(data), 32'h00);
      checkOutput("reset_valid", 32'(valid), 32'h0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
      checkOutput("reset_overrun", 32'(overrun), 32'h0);
      checkOutput("reset_parity_err", 32'(parity_err), 32'h0);
      rst_n = 1'b1;
      waitClocks(BIT_CLKS);

      // Clean byte with ready held high: exactly one valid cycle
      snapCounts();
      ready = 1'b1;
      applyStimulus(8'h61, 1'b1);
      waitClocks(BIT_CLKS);
      checkOutput("clean_valid_cycles", 32'(valid_seen - v0), 32'd1);
      checkOutput("clean_data", 32'(last_data), 32'h61);
      checkOutput("clean_frame_err", 32'(fe_seen - f0), 32'd0);
      checkOutput("clean_overrun", 32'(ov_seen - o0), 32'd0);
      checkOutput("clean_valid_low", 32'(valid), 32'h0);

      // Back-pressure: second byte is dropped with one overrun pulse
      snapCounts();
      ready = 1'b0;
      applyStimulus(8'hA5, 1'b1);
      applyStimulus(8'h3C, 1'b1);
      waitClocks(BIT_CLKS);
      checkOutput("bp_data_held", 32'(data), 32'hA5);
      checkOutput("bp_valid_held", 32'(valid), 32'h1);
      checkOutput("bp_overrun_pulses", 32'(ov_seen - o0), 32'd1);
      ready = 1'b1;
      waitClocks(1);
      checkOutput("bp_valid_drop", 32'(valid), 32'h0);
      waitClocks(BIT_CLKS);
      checkOutput("bp_data_after", 32'(data), 32'hA5);
      checkOutput("bp_last_presented", 32'(last_data), 32'hA5);

      // Framing error followed by a 3-bit break, then a good byte
      snapCounts();
      applyStimulus(8'h55, 1'b0);
      in = 1'b0;
      waitClocks(3 * BIT_CLKS);
      in = 1'b1;
      waitClocks(2 * BIT_CLKS);
      checkOutput("frame_err_pulses", 32'(fe_seen - f0), 32'd1);
      checkOutput("frame_no_valid", 32'(valid_seen - v0), 32'd0);
      applyStimulus(8'h0F, 1'b1);
      waitClocks(BIT_CLKS);
      checkOutput("after_break_valid", 32'(valid_seen - v0), 32'd1);
      checkOutput("after_break_data", 32'(last_data), 32'h0F);
      checkOutput("after_break_fe", 32'(fe_seen - f0), 32'd1);

      // Glitch shorter than half a bit is rejected at the mid-start check
      snapCounts();
      in = 1'b0;
      waitClocks(4);
      in = 1'b1;
      waitClocks(2 * BIT_CLKS);
      checkOutput("glitch_valid", 32'(valid_seen - v0), 32'd0);
      checkOutput("glitch_frame_err", 32'(fe_seen - f0), 32'd0);
      checkOutput("glitch_overrun", 32'(ov_seen - o0), 32'd0);

      // Reset in the middle of data bit 3 of 8'hFF
      in = 1'b0;
      waitClocks(BIT_CLKS);
      in = 1'b1;
      waitClocks(3 * BIT_CLKS + BIT_CLKS / 2);
      rst_n = 1'b0;
      waitClocks(3);
      checkOutput("midrst_data", 32'(data), 32'h00);
      checkOutput("midrst_valid", 32'(valid), 32'h0);
      checkOutput("midrst_frame_err", 32'(frame_err), 32'h0);
      checkOutput("midrst_overrun", 32'(overrun), 32'h0);
      rst_n = 1'b1;
      waitClocks(8 * BIT_CLKS);
      snapCounts();
      applyStimulus(8'h12, 1'b1);
      waitClocks(BIT_CLKS);
      checkOutput("postrst_valid", 32'(valid_seen - v0), 32'd1);
      checkOutput("postrst_data", 32'(last_data), 32'h12);
      checkOutput("postrst_frame_err", 32'(fe_seen - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
      // Wrong even-parity bit: byte still delivered, parity_err pulses once
      snapCounts();
      bad_parity = 1'b1;
      applyStimulus(8'h07, 1'b1);
      bad_parity = 1'b0;
      waitClocks(BIT_CLKS);
      checkOutput("parity_err_pulses", 32'(pe_seen - p0), 32'd1);
      checkOutput("parity_valid", 32'(valid_seen - v0), 32'd1);
      checkOutput("parity_data", 32'(last_data), 32'h07);
      checkOutput("parity_frame_err", 32'(fe_seen - f0), 32'd0);
`else
      checkOutput("parity_err_never", 32'(pe_seen), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
